// File: rtl/csr_trap_controller_pkg.sv
// CSR addresses and sequencer state encoding shared by
// the trap controller and anything that talks to it.
package csr_trap_controller_pkg;

    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WR_MEPC   = 3'd1;
    localparam logic [2:0] S_WR_MCAUSE = 3'd2;
    localparam logic [2:0] S_RD_MTVEC  = 3'd3;
    localparam logic [2:0] S_RD_MEPC   = 3'd4;
    localparam logic [2:0] S_REDIRECT  = 3'd5;

endpackage

// File: rtl/csr_trap_controller_if.sv
// Bundle between pipeline/trap detector, the trap
// controller and the CSR file ports.
interface csr_trap_controller_if #(
    parameter int XLEN = 32
);
    logic            trap_valid;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_pc;
    logic            mret_valid;
    logic            inst_csr_write_enable;
    logic [11:0]     inst_csr_write_address;
    logic [XLEN-1:0] inst_csr_write_data;
    logic [11:0]     inst_csr_read_address;
    logic [XLEN-1:0] csr_read_data;
    logic            csr_ready;
    logic            csr_write_enable;
    logic [11:0]     csr_write_address;
    logic [XLEN-1:0] csr_write_data;
    logic [11:0]     csr_read_address;
    logic            trapped;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            stall;
    logic            busy;

    modport master (
        input  trap_valid, trap_cause, trap_pc, mret_valid,
        input  inst_csr_write_enable, inst_csr_write_address,
        input  inst_csr_write_data, inst_csr_read_address,
        input  csr_read_data, csr_ready,
        output csr_write_enable, csr_write_address,
        output csr_write_data, csr_read_address, trapped,
        output redirect_valid, redirect_pc, stall, busy
    );

    modport slave (
        output trap_valid, trap_cause, trap_pc, mret_valid,
        output inst_csr_write_enable, inst_csr_write_address,
        output inst_csr_write_data, inst_csr_read_address,
        output csr_read_data, csr_ready,
        input  csr_write_enable, csr_write_address,
        input  csr_write_data, csr_read_address, trapped,
        input  redirect_valid, redirect_pc, stall, busy
    );
endinterface

// File: rtl/csr_trap_controller.sv
// Arbitrates the CSR file ports between instructions and
// the trap/mret sequencer, and produces the PC redirect.
module csr_trap_controller
    import csr_trap_controller_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic                   clk,
    input logic                   reset,
    csr_trap_controller_if.master bus
);

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            seen_low_q, seen_low_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            cause_q    <= '0;
            target_q   <= '0;
            seen_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cause_q    <= cause_d;
            target_q   <= target_d;
            seen_low_q <= seen_low_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cause_d    = cause_q;
        target_d   = target_q;
        seen_low_d = seen_low_q;

        bus.csr_write_enable  = 1'b0;
        bus.csr_write_address = '0;
        bus.csr_write_data    = '0;
        bus.csr_read_address  = '0;
        bus.trapped           = 1'b0;
        bus.redirect_valid    = 1'b0;
        bus.redirect_pc       = target_q;
        bus.stall             = 1'b1;
        bus.busy              = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                bus.busy              = 1'b0;
                bus.stall             = ~bus.csr_ready;
                bus.csr_read_address  = bus.inst_csr_read_address;
                bus.csr_write_address = bus.inst_csr_write_address;
                bus.csr_write_data    = bus.inst_csr_write_data;
                bus.csr_write_enable  = bus.inst_csr_write_enable
                                      & ~bus.trap_valid
                                      & ~bus.mret_valid;
                if (bus.trap_valid) begin
                    pc_d    = bus.trap_pc;
                    cause_d = bus.trap_cause;
                    state_d = S_WR_MEPC;
                end else if (bus.mret_valid) begin
                    state_d = S_RD_MEPC;
                end
            end
            S_WR_MEPC: begin
                bus.csr_write_enable  = 1'b1;
                bus.csr_write_address = CSR_MEPC;
                bus.csr_write_data    = pc_q;
                bus.trapped           = 1'b1;
                state_d               = S_WR_MCAUSE;
            end
            S_WR_MCAUSE: begin
                bus.csr_write_enable  = 1'b1;
                bus.csr_write_address = CSR_MCAUSE;
                bus.csr_write_data    = cause_q;
                bus.trapped           = 1'b1;
                state_d               = S_RD_MTVEC;
            end
            S_RD_MTVEC, S_RD_MEPC: begin
                bus.csr_read_address = (state_q == S_RD_MTVEC)
                                     ? CSR_MTVEC : CSR_MEPC;
                // Registered read data is only valid once the file
                // has dropped ready for the new address and raised it.
                if (!bus.csr_ready) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    target_d   = {bus.csr_read_data[XLEN-1:2], 2'b00};
                    seen_low_d = 1'b0;
                    state_d    = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                bus.redirect_valid = 1'b1;
                state_d            = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_csr_trap_controller.sv
// Scoreboard bench: CSR file model plus queues of expected
// writes and redirects, popped as the DUT produces them.
module tb_csr_trap_controller;
    import csr_trap_controller_pkg::*;

    localparam int XLEN = 32;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
        int          c;
    } wr_t;

    typedef struct {
        logic [31:0] pc;
        int          c;
    } rd_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_wr = 0;
    int   n_rd = 0;
    wr_t  wq[$];
    rd_t  rq[$];

    logic [31:0] m_mtvec, m_mepc, m_mcause, rd_q;
    logic [11:0] last_ra;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    csr_trap_controller_if #(.XLEN(XLEN)) bus ();

    csr_trap_controller #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // CSR file model: registered read, ready drops for one
    // cycle whenever the read address changes.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mtvec  <= 32'h1000;
            m_mepc   <= '0;
            m_mcause <= '0;
            last_ra  <= '0;
            rd_q     <= '0;
        end else begin
            last_ra <= bus.csr_read_address;
            case (bus.csr_read_address)
                CSR_MTVEC:  rd_q <= m_mtvec;
                CSR_MEPC:   rd_q <= m_mepc;
                CSR_MCAUSE: rd_q <= m_mcause;
                default:    rd_q <= '0;
            endcase
            if (bus.csr_write_enable) begin
                case (bus.csr_write_address)
                    CSR_MTVEC:  m_mtvec  <= bus.csr_write_data;
                    CSR_MEPC:   m_mepc   <= bus.csr_write_data;
                    CSR_MCAUSE: m_mcause <= bus.csr_write_data;
                    default: ;
                endcase
            end
        end
    end

    assign bus.csr_ready     = (bus.csr_read_address == last_ra);
    assign bus.csr_read_data = rd_q;

    always @(negedge clk) begin
        wr_t ew;
        rd_t er;
        if (!reset) begin
            if (bus.csr_write_enable) begin
                n_wr++;
                n_cmp++;
                if (wq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write got a=%h d=%h cyc=%0d, expected none",
                             bus.csr_write_address, bus.csr_write_data, cyc);
                end else begin
                    ew = wq.pop_front();
                    if ({bus.csr_write_address, bus.csr_write_data, cyc}
                        !== {ew.a, ew.d, ew.c}) begin
                        n_bad++;
                        $display("FAIL csr_write got a=%h d=%h cyc=%0d, expected a=%h d=%h cyc=%0d",
                                 bus.csr_write_address, bus.csr_write_data, cyc,
                                 ew.a, ew.d, ew.c);
                    end
                end
            end
            if (bus.redirect_valid) begin
                n_rd++;
                n_cmp++;
                if (rq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_redirect got pc=%h cyc=%0d, expected none",
                             bus.redirect_pc, cyc);
                end else begin
                    er = rq.pop_front();
                    if ({bus.redirect_pc, cyc} !== {er.pc, er.c}) begin
                        n_bad++;
                        $display("FAIL redirect got pc=%h cyc=%0d, expected pc=%h cyc=%0d",
                                 bus.redirect_pc, cyc, er.pc, er.c);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.trap_valid             = 1'b0;
        bus.trap_cause             = '0;
        bus.trap_pc                = '0;
        bus.mret_valid             = 1'b0;
        bus.inst_csr_write_enable  = 1'b0;
        bus.inst_csr_write_address = '0;
        bus.inst_csr_write_data    = '0;
        bus.inst_csr_read_address  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_in();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.busy, bus.stall, bus.redirect_valid, bus.csr_write_enable,
             bus.trapped} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags got %b, expected 00000",
                     {bus.busy, bus.stall, bus.redirect_valid,
                      bus.csr_write_enable, bus.trapped});
        end
        n_cmp++;
        if (bus.redirect_pc !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_pc got %h, expected 0", bus.redirect_pc);
        end
        reset = 1'b0;
        step();
    endtask

    // Drives a trap in the next cycle and checks stall and the
    // redirect pulse through cycle 5; with_extra adds a
    // simultaneous mret and instruction write to mtvec.
    task automatic run_trap(input logic [31:0] pc, input logic [31:0] cause,
                            input logic [31:0] target, input bit with_extra);
        int c0;
        step();
        c0 = cyc;
        bus.trap_valid = 1'b1;
        bus.trap_pc    = pc;
        bus.trap_cause = cause;
        if (with_extra) begin
            bus.mret_valid             = 1'b1;
            bus.inst_csr_write_enable  = 1'b1;
            bus.inst_csr_write_address = CSR_MTVEC;
            bus.inst_csr_write_data    = 32'h2000;
        end
        wq.push_back('{CSR_MEPC, pc, c0 + 1});
        wq.push_back('{CSR_MCAUSE, cause, c0 + 2});
        rq.push_back('{target, c0 + 5});
        for (int k = 1; k <= 5; k++) begin
            step();
            clear_in();
            @(negedge clk);
            n_cmp++;
            if (bus.stall !== 1'b1) begin
                n_bad++;
                $display("FAIL trap_stall k=%0d got %b, expected 1", k, bus.stall);
            end
            n_cmp++;
            if (bus.redirect_valid !== (k == 5)) begin
                n_bad++;
                $display("FAIL trap_pulse k=%0d got %b, expected %b",
                         k, bus.redirect_valid, (k == 5));
            end
        end
    endtask

    task automatic check_drained(input string tag);
        n_cmp++;
        if (wq.size() != 0 || rq.size() != 0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_drain got wq=%0d rq=%0d busy=%b, expected 0 0 0",
                     tag, wq.size(), rq.size(), bus.busy);
        end
    endtask

    task automatic test_trap();
        run_trap(32'h124, 32'hB, 32'h1000, 1'b0);
        step();
        check_drained("trap");
        n_cmp++;
        if ({m_mepc, m_mcause} !== {32'h124, 32'hB}) begin
            n_bad++;
            $display("FAIL trap_csrs got %h %h, expected 124 b", m_mepc, m_mcause);
        end
    endtask

    task automatic test_mret();
        int c0, w0;
        step();
        bus.inst_csr_write_enable  = 1'b1;
        bus.inst_csr_write_address = CSR_MEPC;
        bus.inst_csr_write_data    = 32'h128;
        wq.push_back('{CSR_MEPC, 32'h128, cyc});
        step();
        c0 = cyc;
        w0 = n_wr;
        // Write presented with mret must be suppressed.
        bus.inst_csr_write_address = CSR_MCAUSE;
        bus.inst_csr_write_data    = 32'h77;
        bus.mret_valid             = 1'b1;
        rq.push_back('{32'h128, c0 + 3});
        step();
        clear_in();
        @(negedge clk);
        n_cmp++;
        if ({bus.stall, bus.busy, bus.trapped} !== 3'b110) begin
            n_bad++;
            $display("FAIL mret_flags got %b, expected 110",
                     {bus.stall, bus.busy, bus.trapped});
        end
        repeat (4) step();
        check_drained("mret");
        n_cmp++;
        if (n_wr != w0) begin
            n_bad++;
            $display("FAIL mret_writes got %0d, expected 0", n_wr - w0);
        end
    endtask

    task automatic test_simultaneous();
        run_trap(32'h200, 32'h3, 32'h1000, 1'b1);
        step();
        check_drained("simul");
        n_cmp++;
        if (m_mtvec !== 32'h1000) begin
            n_bad++;
            $display("FAIL simul_mtvec got %h, expected 1000", m_mtvec);
        end
    endtask

    task automatic test_back_to_back();
        step();
        bus.inst_csr_write_enable  = 1'b1;
        bus.inst_csr_write_address = CSR_MTVEC;
        bus.inst_csr_write_data    = 32'h2003;
        wq.push_back('{CSR_MTVEC, 32'h2003, cyc});
        @(negedge clk);
        n_cmp++;
        if ({bus.csr_write_enable, bus.csr_write_address, bus.csr_write_data,
             bus.stall} !== {1'b1, CSR_MTVEC, 32'h2003, 1'b0}) begin
            n_bad++;
            $display("FAIL pass_write got %b %h %h %b, expected 1 305 00002003 0",
                     bus.csr_write_enable, bus.csr_write_address,
                     bus.csr_write_data, bus.stall);
        end
        run_trap(32'h300, 32'h4, 32'h2000, 1'b0);
        run_trap(32'h304, 32'h5, 32'h2000, 1'b0);
        step();
        check_drained("b2b");
    endtask

    task automatic test_retrigger();
        int c0, w0, r0;
        step();
        c0 = cyc;
        w0 = n_wr;
        r0 = n_rd;
        bus.trap_valid = 1'b1;
        bus.trap_pc    = 32'h140;
        bus.trap_cause = 32'h2;
        wq.push_back('{CSR_MEPC, 32'h140, c0 + 1});
        wq.push_back('{CSR_MCAUSE, 32'h2, c0 + 2});
        rq.push_back('{32'h2000, c0 + 5});
        step();
        clear_in();
        step();
        bus.trap_valid = 1'b1;
        bus.trap_pc    = 32'h999;
        bus.trap_cause = 32'h99;
        step();
        clear_in();
        repeat (6) step();
        check_drained("retrig");
        n_cmp++;
        if ({n_wr - w0, n_rd - r0} !== {32'd2, 32'd1}) begin
            n_bad++;
            $display("FAIL retrig_counts got wr=%0d rd=%0d, expected 2 1",
                     n_wr - w0, n_rd - r0);
        end
    endtask

    task automatic test_reset_mid();
        int c0, w0, r0;
        step();
        c0 = cyc;
        bus.trap_valid = 1'b1;
        bus.trap_pc    = 32'h180;
        bus.trap_cause = 32'h7;
        wq.push_back('{CSR_MEPC, 32'h180, c0 + 1});
        wq.push_back('{CSR_MCAUSE, 32'h7, c0 + 2});
        step();
        clear_in();
        step();
        step();
        n_cmp++;
        if ({bus.busy, bus.csr_read_address} !== {1'b1, CSR_MTVEC}) begin
            n_bad++;
            $display("FAIL mid_state got busy=%b ra=%h, expected 1 305",
                     bus.busy, bus.csr_read_address);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.busy, bus.stall, bus.redirect_valid} !== 3'b000) begin
            n_bad++;
            $display("FAIL mid_flags got %b, expected 000",
                     {bus.busy, bus.stall, bus.redirect_valid});
        end
        n_cmp++;
        if (bus.redirect_pc !== 32'h0) begin
            n_bad++;
            $display("FAIL mid_pc got %h, expected 0", bus.redirect_pc);
        end
        step();
        step();
        reset = 1'b0;
        w0 = n_wr;
        r0 = n_rd;
        repeat (8) step();
        n_cmp++;
        if ({n_wr - w0, n_rd - r0} !== {32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL mid_after got wr=%0d rd=%0d, expected 0 0",
                     n_wr - w0, n_rd - r0);
        end
        n_cmp++;
        if ({m_mepc, m_mcause} !== 64'h0) begin
            n_bad++;
            $display("FAIL mid_csrs got %h %h, expected 0 0", m_mepc, m_mcause);
        end
        check_drained("mid");
    endtask

    initial begin
        reset = 1'b1;
        clear_in();
        test_reset();
        test_trap();
        test_mret();
        test_simultaneous();
        test_back_to_back();
        test_retrigger();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
